// File: rtl/deemphasis_pkg.sv
// deemphasis_pkg: coefficient elaboration, time constants and channel-tag helpers for deemphasis_iir
package deemphasis_pkg;
  localparam real TAU_50US = 50.0e-6;
  localparam real TAU_75US = 75.0e-6;
  localparam int DEF_CHANNELS = 2;
  function automatic int chan_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [chan_bits(DEF_CHANNELS)-1:0] chan_t;
  // b = round((1 - exp(-1/(tau*fs))) * 2^cw); exp by Taylor series keeps this a pure constant function
  function automatic int iir_coef(input real tau, input int fs, input int cw);
    real a;
    real term;
    real e;
    real scale;
    a = -1.0 / (tau * fs);
    term = 1.0;
    e = 1.0;
    for (int k = 1; k < 40; k++) begin
      term = term * a / k;
      e = e + term;
    end
    scale = 1.0;
    for (int k = 0; k < cw; k++) scale = scale * 2.0;
    return $rtoi((1.0 - e) * scale + 0.5);
  endfunction
endpackage

// File: rtl/deemphasis_state_ram.sv
// deemphasis_state_ram: per-channel filter state, async read, one write port, zeroed by reset or clear
module deemphasis_state_ram
  import deemphasis_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 2,
  parameter int CHW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    we,
  input  logic [CHW-1:0]          waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [CHW-1:0]          raddr,
  output logic signed [WIDTH-1:0] rdata
);
  logic signed [WIDTH-1:0] mem_q [CHANNELS];
  logic signed [WIDTH-1:0] mem_d [CHANNELS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    if (clear) for (int i = 0; i < CHANNELS; i++) mem_d[i] = '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < CHANNELS; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  end
  assign rdata = (32'(raddr) < CHANNELS) ? mem_q[raddr] : '0;
endmodule

// File: rtl/deemphasis_iir.sv
// deemphasis_iir: 3-stage multi-channel de-emphasis IIR with state forwarding; DEEMPHASIS_BYPASS_EN adds a bypass port
module deemphasis_iir
  import deemphasis_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 2,
  parameter int CW = 16,
  parameter int FS = 32000,
  localparam int CHW = chan_bits(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    tau_sel,
  input  logic                    in_valid,
  input  logic [CHW-1:0]          in_chan,
  input  logic signed [WIDTH-1:0] in_data,
`ifdef DEEMPHASIS_BYPASS_EN
  input  logic                    bypass,
`endif
  output logic                    out_valid,
  output logic [CHW-1:0]          out_chan,
  output logic signed [WIDTH-1:0] out_data
);
  localparam int PW = WIDTH + CW + 2;
  localparam int B50I = iir_coef(TAU_50US, FS, CW);
  localparam int B75I = iir_coef(TAU_75US, FS, CW);
  localparam logic signed [CW:0] B50 = B50I[CW:0];
  localparam logic signed [CW:0] B75 = B75I[CW:0];
  localparam logic signed [PW-1:0] HALF = PW'(1) << (CW - 1);
  logic v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
  logic [CHW-1:0] c1_q, c1_d, c2_q, c2_d, oc_q, oc_d;
  logic signed [WIDTH-1:0] x1_q, x1_d, y1_q, y1_d, y2_q, y2_d, od_q, od_d;
  logic signed [WIDTH-1:0] y_rd, y_op, y_res, y_out;
  logic signed [CW:0] b1_q, b1_d;
  logic signed [PW-1:0] p2_q, p2_d;
  logic signed [WIDTH:0] diff;
`ifdef DEEMPHASIS_BYPASS_EN
  logic bp1_q, bp1_d, bp2_q, bp2_d;
  logic signed [WIDTH-1:0] x2_q, x2_d;
`endif
  deemphasis_state_ram #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CHW(CHW)) u_ram (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .we(v2_q),
    .waddr(c2_q),
    .wdata(y_res),
    .raddr(in_chan),
    .rdata(y_rd)
  );
  // The newest same-channel result always wins: S2's fresh result overrides the S1-time read
  always_comb begin
    y_res = y2_q + WIDTH'((p2_q + HALF) >>> CW);
    v1_d = in_valid && (32'(in_chan) < CHANNELS) && !clear;
    c1_d = in_chan;
    x1_d = in_data;
    b1_d = tau_sel ? B75 : B50;
    y1_d = (v2_q && c2_q == in_chan) ? y_res : y_rd;
    y_op = (v2_q && c2_q == c1_q) ? y_res : y1_q;
    diff = {x1_q[WIDTH-1], x1_q} - {y_op[WIDTH-1], y_op};
    p2_d = PW'(diff) * PW'(b1_q);
    v2_d = v1_q && !clear;
    c2_d = c1_q;
    y2_d = y_op;
`ifdef DEEMPHASIS_BYPASS_EN
    bp1_d = bypass;
    bp2_d = bp1_q;
    x2_d = x1_q;
    y_out = bp2_q ? x2_q : y_res;
`else
    y_out = y_res;
`endif
    ov_d = v2_q && !clear;
    oc_d = ov_d ? c2_q : oc_q;
    od_d = ov_d ? y_out : od_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      ov_q <= 1'b0;
      c1_q <= '0;
      c2_q <= '0;
      oc_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      od_q <= '0;
      b1_q <= '0;
      p2_q <= '0;
`ifdef DEEMPHASIS_BYPASS_EN
      bp1_q <= 1'b0;
      bp2_q <= 1'b0;
      x2_q <= '0;
`endif
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      ov_q <= ov_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      oc_q <= oc_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      od_q <= od_d;
      b1_q <= b1_d;
      p2_q <= p2_d;
`ifdef DEEMPHASIS_BYPASS_EN
      bp1_q <= bp1_d;
      bp2_q <= bp2_d;
      x2_q <= x2_d;
`endif
    end
  end
  assign out_valid = ov_q;
  assign out_chan = oc_q;
  assign out_data = od_q;
endmodule

// File: tb/tb_deemphasis_iir.sv
// tb_deemphasis_iir: table vectors, hazard/clear/reset sequences and random stimulus against a sequential model
module tb_deemphasis_iir;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic tau_sel = 1'b0;
  logic in_valid = 1'b0;
  logic in_chan = 1'b0;
  logic signed [15:0] in_data = '0;
  logic bypass = 1'b0;
  bit bp_next = 1'b0;
  logic out_valid;
  logic out_chan;
  logic signed [15:0] out_data;
  always #5 clk = ~clk;
  deemphasis_iir dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .tau_sel(tau_sel),
    .in_valid(in_valid),
    .in_chan(in_chan),
    .in_data(in_data),
`ifdef DEEMPHASIS_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid),
    .out_chan(out_chan),
    .out_data(out_data)
  );
  typedef struct {int due; int ch; int d;} exp_t;
  typedef struct {bit ch; bit tau; int x; int e;} vec_t;
  exp_t q[$];
  vec_t tbl[8];
  longint ym[2];
  int checks = 0;
  int errors = 0;
  int it = 0;
  int last_d = 0;
  int last_c = 0;
  string tag = "reset";
  function automatic int model(input int ch, input bit tau, input int x);
    longint b;
    longint d;
    b = tau ? 64'sd22332 : 64'sd30457;
    d = longint'(x) - ym[ch];
    ym[ch] = ym[ch] + ((d * b + 64'sd32768) >>> 16);
    return int'(ym[ch]);
  endfunction
  task automatic check_out();
    exp_t e;
    checks++;
    if (q.size() > 0 && q[0].due == it) begin
      e = q.pop_front();
      if (!(out_valid === 1'b1 && int'(out_chan) == e.ch && int'(out_data) == e.d)) begin
        errors++;
        $display("FAIL %s it=%0d: got v=%0b ch=%0d d=%0d, want v=1 ch=%0d d=%0d",
                 tag, it, out_valid, out_chan, out_data, e.ch, e.d);
      end
      last_d = e.d;
      last_c = e.ch;
    end else if (!(out_valid === 1'b0 && int'(out_data) == last_d && int'(out_chan) == last_c)) begin
      errors++;
      $display("FAIL %s it=%0d idle: got v=%0b ch=%0d d=%0d, want v=0 ch=%0d d=%0d",
               tag, it, out_valid, out_chan, out_data, last_c, last_d);
    end
  endtask
  task automatic cycle(input bit v, input int ch, input bit tau, input int x,
                       input bit clr, input bit has, input int ev);
    int m;
    @(negedge clk);
    check_out();
    in_valid = v;
    in_chan = ch[0];
    tau_sel = tau;
    in_data = 16'(x);
    clear = clr;
    bypass = bp_next;
    if (clr) begin
      q.delete();
      ym[0] = 0;
      ym[1] = 0;
    end else if (v) begin
      m = model(ch, tau, x);
      q.push_back('{it + 3, ch, has ? ev : m});
    end
    it++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int b2b[5] = '{465, 714, 847, 918, 956};
    int st[6] = '{465, -465, 714, -714, 847, -847};
    int x;
    int sel;
    tbl[0] = '{0, 0, 1000, 465};
    tbl[1] = '{0, 0, 1000, 714};
    tbl[2] = '{1, 1, 1000, 341};
    tbl[3] = '{0, 0, 1000, 847};
    tbl[4] = '{1, 1, 1000, 566};
    tbl[5] = '{1, 1, 0, 373};
    tbl[6] = '{0, 0, -1000, -11};
    tbl[7] = '{0, 1, 32767, 11158};
    ym[0] = 0;
    ym[1] = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tag = "table";
    for (int i = 0; i < 8; i++) begin
      cycle(1, tbl[i].ch, tbl[i].tau, tbl[i].x, 0, 1, tbl[i].e);
      idle(3);
    end
    tag = "b2b";
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1000, 0, 1, b2b[i]);
    idle(3);
    tag = "stereo";
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, i % 2, 0, (i % 2) ? -1000 : 1000, 0, 1, st[i]);
    idle(3);
    tag = "clear";
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1000, 0, 1, 465);
    cycle(1, 1, 0, 1000, 0, 1, 465);
    cycle(1, 0, 0, 1000, 1, 0, 0);
    idle(3);
    cycle(1, 0, 0, 1000, 0, 1, 465);
    idle(3);
    tag = "reset";
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1000, 0, 0, 0);
    idle(3);
    cycle(1, 0, 0, 1000, 0, 0, 0);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (!(out_valid === 1'b0 && out_data == 16'sd0 && out_chan == 1'b0)) begin
      errors++;
      $display("FAIL async_reset: got v=%0b ch=%0d d=%0d, want v=0 ch=0 d=0", out_valid, out_chan, out_data);
    end
    q.delete();
    ym[0] = 0;
    ym[1] = 0;
    last_d = 0;
    last_c = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    cycle(1, 0, 0, 1000, 0, 1, 465);
    idle(3);
    tag = "random";
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 7);
      x = (sel == 0) ? 32767 : (sel == 1) ? -32768 : int'($signed(16'($urandom)));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), 1'($urandom_range(0, 1)), x, 0, 0, 0);
    end
    idle(4);
`ifdef DEEMPHASIS_BYPASS_EN
    tag = "bypass";
    cycle(0, 0, 0, 0, 1, 0, 0);
    bp_next = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1000, 0, 1, 1000);
    bp_next = 1'b0;
    cycle(1, 0, 0, 1000, 0, 0, 0);
    idle(4);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
